// File: rtl/eflags_pkg.sv
`default_nettype none
// ============================================================================
// Package : eflags_pkg
// Brief   : EFLAGS bit positions, mask order, tttn codes, FSM states.
// Rev     : 1.0
// ============================================================================
package eflags_pkg;

  localparam int OF_BIT = 11;
  localparam int DF_BIT = 10;
  localparam int SF_BIT = 7;
  localparam int ZF_BIT = 6;
  localparam int AF_BIT = 4;
  localparam int PF_BIT = 2;
  localparam int CF_BIT = 0;

  // wb_mask order is {OF,DF,SF,ZF,AF,PF,CF}
  localparam int M_CF = 0;
  localparam int M_PF = 1;
  localparam int M_AF = 2;
  localparam int M_ZF = 3;
  localparam int M_SF = 4;
  localparam int M_DF = 5;
  localparam int M_OF = 6;

  localparam logic [31:0] FLAG_MASK = 32'h0000_0CD5;

  typedef enum logic [3:0] {
    CC_O  = 4'h0, CC_NO  = 4'h1, CC_B  = 4'h2, CC_NB  = 4'h3,
    CC_E  = 4'h4, CC_NE  = 4'h5, CC_BE = 4'h6, CC_NBE = 4'h7,
    CC_S  = 4'h8, CC_NS  = 4'h9, CC_P  = 4'hA, CC_NP  = 4'hB,
    CC_L  = 4'hC, CC_NL  = 4'hD, CC_LE = 4'hE, CC_NLE = 4'hF
  } cc_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic [31:0] merge_flags(input logic [31:0] old_f,
                                              input logic [31:0] new_f,
                                              input logic [6:0]  mask);
    logic [31:0] wmask;
    wmask         = '0;
    wmask[OF_BIT] = mask[M_OF];
    wmask[DF_BIT] = mask[M_DF];
    wmask[SF_BIT] = mask[M_SF];
    wmask[ZF_BIT] = mask[M_ZF];
    wmask[AF_BIT] = mask[M_AF];
    wmask[PF_BIT] = mask[M_PF];
    wmask[CF_BIT] = mask[M_CF];
    return ((old_f & ~wmask) | (new_f & wmask)) & FLAG_MASK;
  endfunction

endpackage
`default_nettype wire

// File: rtl/eflags_cond_eval_if.sv
`default_nettype none
// ============================================================================
// Interface : eflags_cond_eval_if
// Brief     : Flag writeback, issue tracking and condition query signals.
// Rev       : 1.0
// ============================================================================
interface eflags_cond_eval_if;

  logic        issue_fw;
  logic        issue_full;
  logic        wb_valid;
  logic [31:0] wb_flags;
  logic [6:0]  wb_mask;
  logic        flush;
  logic        cc_req_valid;
  logic [3:0]  cc_req_cond;
  logic        cc_req_ready;
  logic        cc_rsp_valid;
  logic        cc_rsp_taken;
  logic [31:0] flags_out;

  modport master (
    output issue_fw, wb_valid, wb_flags, wb_mask, flush, cc_req_valid, cc_req_cond,
    input  issue_full, cc_req_ready, cc_rsp_valid, cc_rsp_taken, flags_out
  );

  modport slave (
    input  issue_fw, wb_valid, wb_flags, wb_mask, flush, cc_req_valid, cc_req_cond,
    output issue_full, cc_req_ready, cc_rsp_valid, cc_rsp_taken, flags_out
  );

endinterface
`default_nettype wire

// File: rtl/cc_decode.sv
`default_nettype none
// ============================================================================
// Module : cc_decode
// Brief  : x86 tttn condition evaluation on an EFLAGS word (combinational).
// Rev    : 1.0
// ============================================================================
module cc_decode
  import eflags_pkg::*;
(
  input  logic [31:0] i_flags,
  input  logic [3:0]  i_cond,
  output logic        o_taken
);

  logic w_of, w_sf, w_zf, w_pf, w_cf, w_base;
  logic w_unused;

  assign w_of     = i_flags[OF_BIT];
  assign w_sf     = i_flags[SF_BIT];
  assign w_zf     = i_flags[ZF_BIT];
  assign w_pf     = i_flags[PF_BIT];
  assign w_cf     = i_flags[CF_BIT];
  assign w_unused = ^{i_flags[31:12], i_flags[DF_BIT], i_flags[9:8],
                      i_flags[5], i_flags[AF_BIT], i_flags[3], i_flags[1]};

  // Even codes test the condition; the odd partner is its inverse.
  always_comb begin
    w_base = 1'b0;
    case (cc_e'({i_cond[3:1], 1'b0}))
      CC_O:    w_base = w_of;
      CC_B:    w_base = w_cf;
      CC_E:    w_base = w_zf;
      CC_BE:   w_base = w_cf | w_zf;
      CC_S:    w_base = w_sf;
      CC_P:    w_base = w_pf;
      CC_L:    w_base = w_sf ^ w_of;
      CC_LE:   w_base = w_zf | (w_sf ^ w_of);
      default: w_base = 1'b0;
    endcase
  end

  assign o_taken = w_base ^ i_cond[0];

endmodule
`default_nettype wire

// File: rtl/eflags_cond_eval.sv
`default_nettype none
// ============================================================================
// Module : eflags_cond_eval
// Brief  : Architectural EFLAGS holder with stalled, forwarded cc queries.
// Rev    : 1.0
// ============================================================================
module eflags_cond_eval
  import eflags_pkg::*;
#(
  parameter int          PEND_W    = 3,
  parameter logic [31:0] RST_FLAGS = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  eflags_cond_eval_if.slave  bus
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [31:0]       r_flags, w_merged;
  logic [PEND_W-1:0] r_pend, w_pend_eff;
  state_e            r_state, w_state_nxt;
  logic              r_taken, w_taken, w_ready;

  assign w_merged = bus.wb_valid ? merge_flags(r_flags, bus.wb_flags, bus.wb_mask) : r_flags;

  // Simultaneous issue and writeback cancel, even at the saturation limits.
  always_comb begin
    w_pend_eff = r_pend;
    if (bus.issue_fw && !bus.wb_valid) begin
      if (r_pend != PEND_MAX) w_pend_eff = r_pend + PEND_ONE;
    end else if (bus.wb_valid && !bus.issue_fw) begin
      if (r_pend != '0) w_pend_eff = r_pend - PEND_ONE;
    end
  end

  assign w_ready = bus.cc_req_valid & ~bus.flush & ~reset &
                   (r_state != ST_RESP) & (w_pend_eff == '0);

  cc_decode u_cc_decode (
    .i_flags (w_merged),
    .i_cond  (bus.cc_req_cond),
    .o_taken (w_taken)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_ready)               w_state_nxt = ST_RESP;
        else if (bus.cc_req_valid) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (!bus.cc_req_valid) w_state_nxt = ST_IDLE;
        else if (w_ready)      w_state_nxt = ST_RESP;
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (bus.flush) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags <= RST_FLAGS;
      r_pend  <= '0;
      r_state <= ST_IDLE;
      r_taken <= 1'b0;
    end else begin
      r_flags <= w_merged;
      r_pend  <= bus.flush ? '0 : w_pend_eff;
      r_state <= w_state_nxt;
      if (w_ready) r_taken <= w_taken;
    end
  end

  assign bus.issue_full   = (r_pend == PEND_MAX);
  assign bus.cc_req_ready = w_ready;
  assign bus.cc_rsp_valid = (r_state == ST_RESP) & ~bus.flush;
  assign bus.cc_rsp_taken = r_taken;
  assign bus.flags_out    = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_eflags_cond_eval.sv
`default_nettype none
// ============================================================================
// Module : tb_eflags_cond_eval
// Brief  : Directed vectors with a response scoreboard for eflags_cond_eval.
// Rev    : 1.0
// ============================================================================
module tb_eflags_cond_eval;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  eflags_cond_eval_if bus ();

  eflags_cond_eval #(
    .PEND_W    (3),
    .RST_FLAGS (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  bit exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every response pulse consumes one expected outcome.
  always @(negedge clk) begin
    if (!reset && bus.cc_rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_rsp: rsp_valid=1 taken=%0b with no query outstanding",
                 bus.cc_rsp_taken);
      end else begin
        check("rsp_taken", {31'b0, bus.cc_rsp_taken}, {31'b0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.issue_fw     = 1'b0;
    bus.wb_valid     = 1'b0;
    bus.wb_flags     = 32'h0;
    bus.wb_mask      = 7'h00;
    bus.flush        = 1'b0;
    bus.cc_req_valid = 1'b0;
    bus.cc_req_cond  = 4'h0;
  endtask

  task automatic wb(input logic [31:0] f, input logic [6:0] m);
    bus.wb_valid = 1'b1;
    bus.wb_flags = f;
    bus.wb_mask  = m;
    tick();
    bus.wb_valid = 1'b0;
  endtask

  // Present a query until accepted (bounded), then confirm the next-cycle pulse.
  task automatic query(input logic [3:0] c, input bit exp, output int waits);
    exp_q.push_back(exp);
    bus.cc_req_valid = 1'b1;
    bus.cc_req_cond  = c;
    waits = 0;
    #2;
    while (!bus.cc_req_ready && waits < 20) begin
      tick();
      waits++;
      #2;
    end
    if (!bus.cc_req_ready) begin
      check("query_timeout", {31'b0, bus.cc_req_ready}, 32'h1);
      void'(exp_q.pop_back());
      bus.cc_req_valid = 1'b0;
      tick();
    end else begin
      tick();
      bus.cc_req_valid = 1'b0;
      #2;
      check("rsp_latency", {31'b0, bus.cc_rsp_valid}, 32'h1);
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int w;
    idle_inputs();
    reset = 1'b1;
    bus.cc_req_valid = 1'b1;
    repeat (2) tick();
    #2;
    check("reset_flags", bus.flags_out, 32'h0);
    check("reset_rsp_valid", {31'b0, bus.cc_rsp_valid}, 32'h0);
    check("reset_rsp_taken", {31'b0, bus.cc_rsp_taken}, 32'h0);
    check("reset_ready", {31'b0, bus.cc_req_ready}, 32'h0);
    check("reset_full", {31'b0, bus.issue_full}, 32'h0);
    bus.cc_req_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // Query E with nothing in flight: accepted immediately, ZF=0.
    query(4'h4, 1'b0, w);
    check("t1_waits", w, 32'd0);

    // One writer in flight: stall, then accept on its writeback cycle.
    bus.issue_fw = 1'b1;
    tick();
    bus.issue_fw = 1'b0;
    exp_q.push_back(1'b1);
    bus.cc_req_valid = 1'b1;
    bus.cc_req_cond  = 4'h2;
    #2;
    check("t2_stall", {31'b0, bus.cc_req_ready}, 32'h0);
    tick();
    bus.wb_valid = 1'b1;
    bus.wb_flags = 32'h0000_0001;
    bus.wb_mask  = 7'h01;
    #2;
    check("t2_fwd_ready", {31'b0, bus.cc_req_ready}, 32'h1);
    tick();
    bus.wb_valid     = 1'b0;
    bus.cc_req_valid = 1'b0;
    #2;
    check("t2_rsp_valid", {31'b0, bus.cc_rsp_valid}, 32'h1);
    check("t2_flags", bus.flags_out, 32'h0000_0001);
    tick();

    // Partial mask write with reserved bits set in the source.
    wb(32'hFFFF_FFFF, 7'b000_0110);
    #2;
    check("t3_partial", bus.flags_out, 32'h0000_0015);
    wb(32'h0000_0880, 7'h7F);
    #2;
    check("t3_full_mask", bus.flags_out, 32'h0000_0880);
    query(4'hC, 1'b0, w);
    query(4'hD, 1'b1, w);
    query(4'hE, 1'b0, w);
    query(4'h8, 1'b1, w);
    query(4'h0, 1'b1, w);
    query(4'h3, 1'b1, w);
    query(4'hA, 1'b0, w);

    // Fill the pending counter to its limit.
    bus.issue_fw = 1'b1;
    repeat (6) tick();
    #2;
    check("t4_not_full_6", {31'b0, bus.issue_full}, 32'h0);
    tick();
    #2;
    check("t4_full_7", {31'b0, bus.issue_full}, 32'h1);
    bus.wb_valid = 1'b1;
    bus.wb_mask  = 7'h00;
    tick();
    bus.wb_valid = 1'b0;
    #2;
    check("t4_both_hold", {31'b0, bus.issue_full}, 32'h1);
    tick();
    bus.issue_fw = 1'b0;
    #2;
    check("t4_issue_at_max", {31'b0, bus.issue_full}, 32'h1);
    wb(32'h0, 7'h00);
    #2;
    check("t4_dec_to_6", {31'b0, bus.issue_full}, 32'h0);
    repeat (4) wb(32'h0, 7'h00);

    // Query stuck behind two writers, then flushed with a ZF writeback.
    bus.cc_req_valid = 1'b1;
    bus.cc_req_cond  = 4'h4;
    #2;
    check("t5_wait_a", {31'b0, bus.cc_req_ready}, 32'h0);
    tick();
    #2;
    check("t5_wait_b", {31'b0, bus.cc_req_ready}, 32'h0);
    tick();
    bus.flush    = 1'b1;
    bus.wb_valid = 1'b1;
    bus.wb_flags = 32'h0000_0040;
    bus.wb_mask  = 7'h08;
    #2;
    check("t5_flush_ready", {31'b0, bus.cc_req_ready}, 32'h0);
    tick();
    bus.flush    = 1'b0;
    bus.wb_valid = 1'b0;
    #2;
    check("t5_flush_wb", bus.flags_out, 32'h0000_08C0);
    exp_q.push_back(1'b1);
    check("t5_reaccept", {31'b0, bus.cc_req_ready}, 32'h1);
    tick();
    bus.cc_req_valid = 1'b0;
    #2;
    check("t5_rsp_valid", {31'b0, bus.cc_rsp_valid}, 32'h1);
    tick();

    // Reset lands in the response cycle: the pulse must vanish.
    bus.cc_req_valid = 1'b1;
    bus.cc_req_cond  = 4'h4;
    #2;
    check("t6_ready", {31'b0, bus.cc_req_ready}, 32'h1);
    tick();
    bus.cc_req_valid = 1'b0;
    reset = 1'b1;
    #2;
    check("t6_rsp_killed", {31'b0, bus.cc_rsp_valid}, 32'h0);
    check("t6_flags", bus.flags_out, 32'h0);
    check("t6_taken", {31'b0, bus.cc_rsp_taken}, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    query(4'h4, 1'b0, w);
    check("t6_post_waits", w, 32'd0);

    repeat (3) tick();
    check("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
